// File: rtl/fi_mem_pkg.sv
// fi_mem_pkg: shared response type and address/strobe helpers for the memory responder
package fi_mem_pkg;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } fi_mem_rsp_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
        return r;
    endfunction

    // A 33-bit offset makes addresses below base wrap to a huge value, so one compare covers both ends
    function automatic logic addr_error(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return addr[1:0] != 2'b00 || off >= 33'(depth) * 33'd4;
    endfunction

endpackage

// File: rtl/fi_rsp_fifo.sv
// fi_rsp_fifo: in-order response queue with occupancy count and head view
module fi_rsp_fifo
    import fi_mem_pkg::*;
#(
    parameter int RSP_DEPTH = 2,
    parameter int CW        = $clog2(RSP_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fi_mem_rsp_t   push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output fi_mem_rsp_t   head
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;

    fi_mem_rsp_t   entries [RSP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fi_mem_responder.sv
// fi_mem_responder: word-addressed SRAM answering one req/gnt/recv/ack bus with in-order,
// stallable responses and range/alignment error reporting
module fi_mem_responder
    import fi_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE      = 32'h0,
    parameter int          RSP_DEPTH = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    input  logic        stall_gnt,
    input  logic        stall_rsp
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {WAIT, SHOW} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          acc, err, pop;
    logic [CW-1:0] count;
    fi_mem_rsp_t   push_data, head, next_rsp;
    state_t        state;

    assign idx       = mem_addr[AW+1:2];
    assign err       = addr_error(mem_addr, BASE, DEPTH);
    assign mem_gnt   = !reset && count != CW'(RSP_DEPTH) && !stall_gnt;
    assign acc       = mem_req && mem_gnt;
    assign push_data = '{error: err, rdata: (err || mem_wen) ? 32'h0 : mem[idx]};
    assign pop       = state == SHOW && mem_ack;
    // With an empty queue the entry being accepted is presented directly, giving next-cycle recv
    assign next_rsp  = count != '0 ? head : push_data;

    always_ff @(posedge clock)
        if (acc && mem_wen && !err)
            mem[idx] <= merge_bytes(mem[idx], mem_wdata, mem_strb);

    fi_rsp_fifo #(.RSP_DEPTH(RSP_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (acc),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT;
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= 32'h0;
        end else if (state == WAIT) begin
            if ((count != '0 || acc) && !stall_rsp) begin
                state     <= SHOW;
                mem_recv  <= 1'b1;
                mem_error <= next_rsp.error;
                mem_rdata <= next_rsp.rdata;
            end
        end else if (mem_ack) begin
            state     <= WAIT;
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= 32'h0;
        end
    end

endmodule
